// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes shared with the ALU decoder and the div_seq state encoding
package muldiv_pkg;
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b11001;
    localparam logic [4:0] OP_REMU = 5'b11101;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} div_state_e;
    function automatic logic is_div_op(input logic [4:0] op);
        return op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU;
    endfunction
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle between the execute stage and div_seq
interface div_seq_if #(parameter int XLEN = 32);
    logic            start_i;
    logic [4:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    modport master(output start_i, op_i, dividend_i, divisor_i, flush_i, input busy_o, valid_o, result_o);
    modport slave(input start_i, op_i, dividend_i, divisor_i, flush_i, output busy_o, valid_o, result_o);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {rem, quo}
module div_step #(parameter int XLEN = 32) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_n,
    output logic [XLEN-1:0] quo_n
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    assign shifted = {rem, quo[XLEN-1]};
    assign diff = shifted - {1'b0, dvs};
    assign rem_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_n = {quo[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU/REM/REMU with a one-cycle
// fast path for divide-by-zero and signed overflow
module div_seq import muldiv_pkg::*; #(parameter int XLEN = 32) (
    input logic       clk_i,
    input logic       rst_i,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    div_state_e      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem, quo, dvs, result;
    logic [XLEN-1:0] rem_n, quo_n;
    logic            is_rem, q_sign, r_sign, busy, valid;
    logic            signed_op, rem_op, accept, zero_div, ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    assign signed_op = bus.op_i == OP_DIV || bus.op_i == OP_REM;
    assign rem_op    = bus.op_i == OP_REM || bus.op_i == OP_REMU;
    assign accept    = (state == S_IDLE || state == S_DONE) && bus.start_i && is_div_op(bus.op_i) && !bus.flush_i;
    assign a_mag     = (signed_op && bus.dividend_i[XLEN-1]) ? -bus.dividend_i : bus.dividend_i;
    assign b_mag     = (signed_op && bus.divisor_i[XLEN-1]) ? -bus.divisor_i : bus.divisor_i;
    assign zero_div  = bus.divisor_i == '0;
    assign ovf       = signed_op && bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}} && bus.divisor_i == '1;
    // overflow DIV returns the dividend itself (most negative value)
    assign fast_res  = zero_div ? (rem_op ? bus.dividend_i : '1) : (rem_op ? '0 : bus.dividend_i);
    div_step #(.XLEN(XLEN)) u_step (.rem(rem), .quo(quo), .dvs(dvs), .rem_n(rem_n), .quo_n(quo_n));
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            result <= '0;
            is_rem <= 1'b0;
            q_sign <= 1'b0;
            r_sign <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else if (bus.flush_i) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else if (accept) begin
            is_rem <= rem_op;
            q_sign <= signed_op && (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
            r_sign <= signed_op && bus.dividend_i[XLEN-1];
            rem    <= '0;
            quo    <= a_mag;
            dvs    <= b_mag;
            cnt    <= CW'(XLEN - 1);
            if (zero_div || ovf) begin
                state  <= S_DONE;
                result <= fast_res;
                busy   <= 1'b0;
                valid  <= 1'b1;
            end else begin
                state <= S_BUSY;
                busy  <= 1'b1;
                valid <= 1'b0;
            end
        end else begin
            case (state)
                S_BUSY: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    result <= is_rem ? (r_sign ? -rem : rem) : (q_sign ? -quo : quo);
                    state  <= S_DONE;
                    busy   <= 1'b0;
                    valid  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign bus.busy_o   = busy;
    assign bus.valid_o  = valid;
    assign bus.result_o = result;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed-vector bench for div_seq, latency and result checks
module tb_div_seq;
    import muldiv_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    div_seq_if #(.XLEN(32)) bus ();
    div_seq #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = op;
        bus.dividend_i = a;
        bus.divisor_i = b;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask
    task automatic wait_valid(input int n0, output int lat, output int bc);
        lat = n0;
        bc = 0;
        while (!bus.valid_o && lat < 60) begin
            if (bus.busy_o) bc++;
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat, bc;
        issue(op, a, b);
        wait_valid(1, lat, bc);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, bus.result_o, exp);
        chk({tag, "_busy"}, bc, exp_lat == 1 ? 0 : 33);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, bus.valid_o}, 0);
    endtask
    initial begin
        int lat, bc, vcnt;
        bus.start_i = 1'b0;
        bus.op_i = '0;
        bus.dividend_i = '0;
        bus.divisor_i = '0;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, bus.busy_o}, 0);
        chk("rst_valid", {31'b0, bus.valid_o}, 0);
        chk("rst_result", bus.result_o, 0);
        run("div_neg20_3", OP_DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 34);
        run("rem_neg20_3", OP_REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 34);
        run("remu_big_3", OP_REMU, 32'hFFFFFFEC, 32'd3, 32'h00000002, 34);
        run("divu_max_16", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 34);
        run("div_by0", OP_DIV, 32'h00000055, 32'd0, 32'hFFFFFFFF, 1);
        run("remu_by0", OP_REMU, 32'h00001234, 32'd0, 32'h00001234, 1);
        run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run("div_neg8_neg1", OP_DIV, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h00000008, 34);
        // back-to-back: new start issued in the DONE cycle
        issue(OP_DIV, 32'hFFFFFFEC, 32'd3);
        wait_valid(1, lat, bc);
        chk("b2b_first", bus.result_o, 32'hFFFFFFFA);
        bus.start_i = 1'b1;
        bus.op_i = OP_DIVU;
        bus.dividend_i = 32'd100;
        bus.divisor_i = 32'd7;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("b2b_busy", {31'b0, bus.busy_o}, 1);
        wait_valid(1, lat, bc);
        chk("b2b_lat", lat, 34);
        chk("b2b_res", bus.result_o, 32'd14);
        // flush at accept+10
        issue(OP_DIV, 32'hFFFFFFEC, 32'd3);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_busy", {31'b0, bus.busy_o}, 0);
        chk("flush_valid", {31'b0, bus.valid_o}, 0);
        chk("flush_result", bus.result_o, 32'd14);
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) vcnt++;
        end
        chk("flush_no_valid", vcnt, 0);
        // start during BUSY is ignored
        issue(OP_REMU, 32'hFFFFFFEC, 32'd3);
        repeat (4) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = OP_DIVU;
        bus.dividend_i = 32'd100;
        bus.divisor_i = 32'd7;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_valid(6, lat, bc);
        chk("ign_lat", lat, 34);
        chk("ign_res", bus.result_o, 32'd2);
        @(negedge clk);
        chk("ign_no_restart", {31'b0, bus.busy_o}, 0);
        // reset at accept+20
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_busy", {31'b0, bus.busy_o}, 0);
        chk("rstmid_valid", {31'b0, bus.valid_o}, 0);
        chk("rstmid_result", bus.result_o, 0);
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid_o || bus.busy_o) vcnt++;
        end
        chk("rstmid_quiet", vcnt, 0);
        // invalid opcode
        issue(5'b00000, 32'd100, 32'd7);
        chk("inv_busy", {31'b0, bus.busy_o}, 0);
        chk("inv_valid", {31'b0, bus.valid_o}, 0);
        @(negedge clk);
        chk("inv_valid2", {31'b0, bus.valid_o}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU). It replaces the single-cycle combinational divider path in the execute stage with a 32-iteration restoring divider, stalling the pipeline while it runs. Divide-by-zero and signed-overflow cases take a one-cycle fast path. The execute stage routes divide opcodes here, holds the pipeline on `busy_o`, and muxes `result_o` onto the writeback path when `valid_o` is high.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; iteration count equals `XLEN`.

Ports:
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `start_i` input 1: request; sampled only in IDLE or DONE.
- `op_i` input 5: ALU operation code. Codes: 5'b10001 DIV, 5'b10101 DIVU, 5'b11001 REM, 5'b11101 REMU. Other codes are ignored.
- `dividend_i` input XLEN: rs1 value; sampled with `start_i`.
- `divisor_i` input XLEN: rs2 value; sampled with `start_i`.
- `flush_i` input 1: aborts any operation in flight.
- `busy_o` output 1: high in BUSY and FIX; pipeline stall request.
- `valid_o` output 1: one-cycle pulse; `result_o` is valid.
- `result_o` output XLEN: quotient or remainder, held until the next accept.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - BUSY: iterating; counter runs 31..0.
  - FIX: sign-correction cycle.
  - DONE: `valid_o` = 1.
- **Accept:** in IDLE or DONE, with `start_i` = 1, a valid `op_i` and `flush_i` = 0:
  - Latch the op, the operand magnitudes, the quotient sign and the remainder sign.
  - Signed ops: magnitude = two's-complement absolute value. 0x80000000 maps to 0x80000000, treated as unsigned.
  - Quotient sign = `dividend[31] ^ divisor[31]`.
  - Remainder sign = `dividend[31]`.
  - Unsigned ops: both signs are 0.
- **Fast path:** decided at accept; the next state is DONE.
  - Divisor == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend unchanged.
  - Signed overflow applies only when dividend == 0x80000000 and divisor == 0xFFFFFFFF, for DIV/REM. DIV returns 0x80000000; REM returns 0.
  - Any other negative dividend with divisor −1 takes the normal path.
- **Normal path:** IDLE → BUSY.
  - Each BUSY cycle performs one restoring step on a {remainder[XLEN], quotient[XLEN]} register pair:
    - Shift left by 1.
    - Trial-subtract the divisor magnitude from the upper half, using an XLEN+1-bit subtract.
    - If non-negative, keep the difference and set quotient bit 0.
  - When the counter reaches 0, go to FIX.
  - FIX negates the quotient or remainder per the latched sign and loads `result_o`, then goes to DONE.
- **DONE:** `valid_o` = 1 for exactly one cycle. Next state is IDLE, or a new accept (back-to-back start is legal).
- **Busy:** `start_i` is ignored in BUSY and FIX. The operands need not be held after the accept.
- **Flush:** `flush_i` = 1 in any state sends the FSM to IDLE on the next edge and suppresses `valid_o`. `flush_i` has priority over `start_i` in the same cycle. `result_o` is not updated.

## Timing
- **Reset:** on `rst_i`, state = IDLE; `busy_o`, `valid_o`, `result_o` and all internal registers are 0. Reset takes precedence over `flush_i` and `start_i`. Reset mid-operation discards the operation with no `valid_o`.
- **Normal path:** accept at edge E0; BUSY during edges E1..E32; FIX at E33; `valid_o` is high in the cycle after E33. That is 34 cycles from accept to result. `busy_o` is high for the 33 cycles after E0.
- **Fast path:** `valid_o` is high in the cycle after E0. `busy_o` stays 0.
- **Outputs:** all are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`: the opcode localparams (DIV/DIVU/REM/REMU codes, shared with the ALU decoder) and the state enumeration for `div_seq`.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once and reused every cycle.

## Test plan
- **DIV, normal path:** dividend −20 (0xFFFFFFEC), divisor 3 → `valid_o` at accept+34 with result 0xFFFFFFFA (−6). `busy_o` is high for 33 cycles.
- **REM / REMU, normal path:** REM of −20 by 3 → 0xFFFFFFFE (−2). REMU of 0xFFFFFFEC by 3 → 0x00000002. DIVU of 0xFFFFFFFF by 0x10 → 0x0FFFFFFF.
- **Fast paths:**
  - DIV x/0 → 0xFFFFFFFF at accept+1.
  - REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000 by −1 → 0x80000000.
  - REM 0x80000000 by −1 → 0.
  - DIV −8 by −1 → 8 via the normal path at accept+34.
- **Back-to-back:** assert `start_i` in the DONE cycle with DIVU 100/7 → accepted; next result 14 with no idle gap.
- **Flush and reset mid-operation:** `flush_i` at accept+10 → IDLE next cycle, no `valid_o`, `result_o` unchanged. Same check with `rst_i` at accept+20 → all outputs 0. `start_i` during BUSY → ignored; the original result is unchanged.
- **Invalid opcode:** `start_i` with `op_i` = 5'b00000 → no accept; `busy_o` and `valid_o` stay 0.
